// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared ALU package: operand width, opcode encoding and sequencer state encoding.
package alu_cmd_sequencer_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpSub = 2'b01,
    OpAnd = 2'b10,
    OpOr  = 2'b11
  } opcode_e;

  // One-hot so each state decodes from a single bit.
  typedef enum logic [4:0] {
    StIdle     = 5'b00001,
    StSendA    = 5'b00010,
    StSendB    = 5'b00100,
    StWaitDone = 5'b01000,
    StResp     = 5'b10000
  } state_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-side and response signals of the ALU command sequencer.
// slave: the sequencer's view; master: the surrounding environment (command source,
// ALU and response sink).
interface alu_cmd_sequencer_if #(
  parameter int unsigned DATA_WIDTH = alu_cmd_sequencer_pkg::DATA_WIDTH
) ();

  // Command channel
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [DATA_WIDTH-1:0] cmd_a;
  logic [DATA_WIDTH-1:0] cmd_b;

  // ALU-side bus
  logic                  opcode_valid;
  logic                  opcode;
  logic [DATA_WIDTH-1:0] data;
  logic                  done;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] result;

  // Response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic                  rsp_overflow;
  logic                  rsp_timeout;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, done, overflow, result, rsp_ready,
    output cmd_ready, opcode_valid, opcode, data, rsp_valid, rsp_result, rsp_overflow,
           rsp_timeout
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, done, overflow, result, rsp_ready,
    input  cmd_ready, opcode_valid, opcode, data, rsp_valid, rsp_result, rsp_overflow,
           rsp_timeout
  );

endinterface

// File: rtl/alu_seq_timer.sv
// WAIT_DONE timeout counter for the ALU command sequencer.
// Only exists when ALU_SEQ_TIMEOUT_EN is defined; otherwise this file is empty so the
// default build carries no counter at all.
`ifdef ALU_SEQ_TIMEOUT_EN
module alu_seq_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,   // high on the cycle before WAIT_DONE entry
  input  logic i_en,      // high while in WAIT_DONE
  output logic o_expired  // high on the terminal WAIT_DONE cycle
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] TermCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] r_cnt;

  // Counts WAIT_DONE cycles; value k means this is the (k+1)-th cycle of the wait.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign o_expired = i_en && (r_cnt == TermCnt);

endmodule
`endif

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: accepts one (op, A, B) command, serialises it onto the ALU bus
// over two cycles, waits for done and holds the response until it is taken.
// Optional feature: define ALU_SEQ_TIMEOUT_EN to abort WAIT_DONE after TIMEOUT_CYCLES.
module alu_cmd_sequencer #(
  parameter int unsigned DATA_WIDTH     = alu_cmd_sequencer_pkg::DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                clk,
  input logic                reset_n,
  alu_cmd_sequencer_if.slave io_bus
);

  import alu_cmd_sequencer_pkg::*;

  state_e                r_state;
  state_e                w_state_next;
  logic [1:0]            r_op;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_rsp_result;
  logic                  r_rsp_overflow;

  logic                  w_cmd_ready;
  logic                  w_cmd_fire;
  logic                  w_in_wait;
  logic                  w_timeout_hit;
  logic                  w_capture_done;
  logic                  w_capture_timeout;
  logic                  w_opcode_valid;
  logic                  w_opcode;
  logic [DATA_WIDTH-1:0] w_data;

  // Gated by reset_n so cmd_ready reads 0 for the whole reset assertion.
  assign w_cmd_ready       = (r_state == StIdle) && reset_n;
  assign w_cmd_fire        = io_bus.cmd_valid && w_cmd_ready;
  assign w_in_wait         = (r_state == StWaitDone);
  // done is only looked at in WAIT_DONE; it wins over a same-cycle timeout.
  assign w_capture_done    = w_in_wait && io_bus.done;
  assign w_capture_timeout = w_in_wait && !io_bus.done && w_timeout_hit;

`ifdef ALU_SEQ_TIMEOUT_EN
  logic r_rsp_timeout;

  alu_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_alu_seq_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (r_state == StSendB),
    .i_en     (w_in_wait),
    .o_expired(w_timeout_hit)
  );

  // Timeout flag: set by an expiry capture, cleared by a normal capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_timeout <= 1'b0;
    end else if (w_capture_done) begin
      r_rsp_timeout <= 1'b0;
    end else if (w_capture_timeout) begin
      r_rsp_timeout <= 1'b1;
    end
  end

  assign io_bus.rsp_timeout = r_rsp_timeout;
`else
  logic w_unused_timeout_cycles;

  assign w_unused_timeout_cycles = |TIMEOUT_CYCLES;
  assign w_timeout_hit           = 1'b0;
  assign io_bus.rsp_timeout      = 1'b0;
`endif

  // FSM state register and command operand capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_cmd_fire) begin
        r_op <= io_bus.cmd_op;
        r_a  <= io_bus.cmd_a;
        r_b  <= io_bus.cmd_b;
      end
    end
  end

  // Response fields: load ALU outputs on done, zero on timeout, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_result   <= '0;
      r_rsp_overflow <= 1'b0;
    end else if (w_capture_done) begin
      r_rsp_result   <= io_bus.result;
      r_rsp_overflow <= io_bus.overflow;
    end else if (w_capture_timeout) begin
      r_rsp_result   <= '0;
      r_rsp_overflow <= 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:     if (w_cmd_fire) w_state_next = StSendA;
      StSendA:    w_state_next = StSendB;
      StSendB:    w_state_next = StWaitDone;
      StWaitDone: if (w_capture_done || w_capture_timeout) w_state_next = StResp;
      StResp:     if (io_bus.rsp_ready) w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  // ALU-side bus: opcode MSB with A, then LSB with B; all zero in every other state.
  always_comb begin
    w_opcode_valid = 1'b0;
    w_opcode       = 1'b0;
    w_data         = '0;
    unique case (r_state)
      StSendA: begin
        w_opcode_valid = 1'b1;
        w_opcode       = r_op[1];
        w_data         = r_a;
      end
      StSendB: begin
        w_opcode_valid = 1'b1;
        w_opcode       = r_op[0];
        w_data         = r_b;
      end
      default: ;
    endcase
  end

  assign io_bus.cmd_ready    = w_cmd_ready;
  assign io_bus.opcode_valid = w_opcode_valid;
  assign io_bus.opcode       = w_opcode;
  assign io_bus.data         = w_data;
  assign io_bus.rsp_valid    = (r_state == StResp);
  assign io_bus.rsp_result   = r_rsp_result;
  assign io_bus.rsp_overflow = r_rsp_overflow;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer. The bench plays command source, ALU and
// response sink; expected responses come from a behavioural ALU model applied to the
// commanded operands.
module tb_alu_cmd_sequencer;

  import alu_cmd_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_cmd_sequencer_if #(.DATA_WIDTH(8)) bus ();

  alu_cmd_sequencer #(
    .DATA_WIDTH    (8),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  // {overflow, result}: carry for ADD, borrow for SUB, none for logic ops.
  function automatic logic [8:0] alu_model(input logic [1:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    case (op)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a} - {1'b0, b};
      2'b10:   return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  // Cycle invariants: never ready and valid together; bus idle outside the send cycles.
  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (bus.rsp_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
        errors++;
        $display("FAIL ready_and_valid got both 1 exp not both");
      end
      checks++;
      if (bus.opcode_valid !== 1'b1 && {bus.opcode, bus.data} !== 9'h0) begin
        errors++;
        $display("FAIL idle_bus got opcode %b data %h exp 0 0", bus.opcode, bus.data);
      end
    end
  end

  // One full transaction starting and ending at a negedge with the DUT idle.
  // dly: WAIT_DONE cycles before done; rdy: cycles of rsp_ready low; spur: done in SEND_A.
  task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input int dly, input int rdy, input bit spur);
    logic [1:0] seen_op;
    logic [7:0] seen_a;
    logic [7:0] seen_b;
    logic [8:0] alu_out;
    logic [8:0] exp_out;
    exp_out = alu_model(op, a, b);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready got %b exp 1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'($urandom); bus.cmd_a = 8'($urandom); bus.cmd_b = 8'($urandom);
    checks++;
    if ({bus.opcode_valid, bus.cmd_ready} !== 2'b10) begin
      errors++;
      $display("FAIL send_a_flags got %b exp 10", {bus.opcode_valid, bus.cmd_ready});
    end
    seen_op[1] = bus.opcode; seen_a = bus.data;
    if (spur) begin
      bus.done = 1'b1; bus.result = 8'($urandom); bus.overflow = 1'($urandom);
    end
    @(negedge clk);
    bus.done = 1'b0;
    checks++;
    if (bus.opcode_valid !== 1'b1) begin
      errors++;
      $display("FAIL send_b_valid got %b exp 1", bus.opcode_valid);
    end
    seen_op[0] = bus.opcode; seen_b = bus.data;
    checks++;
    if ({seen_op, seen_a, seen_b} !== {op, a, b}) begin
      errors++;
      $display("FAIL alu_bus got %h exp %h", {seen_op, seen_a, seen_b}, {op, a, b});
    end
    alu_out = alu_model(seen_op, seen_a, seen_b);
    @(negedge clk);
    for (int i = 0; i < dly; i++) begin
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait_no_rsp cycle %0d got %b exp 0", i, bus.rsp_valid);
      end
      @(negedge clk);
    end
    bus.done = 1'b1; bus.result = alu_out[7:0]; bus.overflow = alu_out[8];
    @(negedge clk);
    bus.done = 1'b0;
    for (int i = 0; i <= rdy; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.cmd_ready, bus.rsp_timeout, bus.rsp_overflow, bus.rsp_result}
          !== {3'b100, exp_out}) begin
        errors++;
        $display("FAIL rsp cycle %0d got v%b r%b t%b o%b %h exp v1 r0 t0 o%b %h", i,
                 bus.rsp_valid, bus.cmd_ready, bus.rsp_timeout, bus.rsp_overflow,
                 bus.rsp_result, exp_out[8], exp_out[7:0]);
      end
      if (i == rdy) begin
        bus.rsp_ready = 1'b1; bus.done = 1'b0;
      end else begin
        bus.done = 1'($urandom); bus.result = 8'($urandom); bus.overflow = 1'($urandom);
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0; bus.done = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_overflow, bus.rsp_result}
        !== {2'b00, exp_out}) begin
      errors++;
      $display("FAIL rsp_retained got v%b t%b o%b %h exp v0 t0 o%b %h", bus.rsp_valid,
               bus.rsp_timeout, bus.rsp_overflow, bus.rsp_result, exp_out[8], exp_out[7:0]);
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({bus.cmd_ready, bus.opcode_valid, bus.opcode, bus.data, bus.rsp_valid,
           bus.rsp_result, bus.rsp_overflow, bus.rsp_timeout} !== 21'h0) begin
        errors++;
        $display("FAIL reset_outputs got nonzero exp all 0 (ready %b rsp_valid %b)",
                 bus.cmd_ready, bus.rsp_valid);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_result} !== {2'b10, 8'h00}) begin
      errors++;
      $display("FAIL post_reset got ready %b valid %b res %h exp 1 0 00", bus.cmd_ready,
               bus.rsp_valid, bus.rsp_result);
    end
  endtask

  task automatic test_add();
    do_op(OpAdd, 8'h12, 8'h34, 0, 0, 1'b0);
  endtask

  task automatic test_overflow();
    do_op(OpAdd, 8'hFF, 8'h01, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_op(OpSub, 8'h10, 8'h20, 1, 5, 1'b0);
    do_op(OpOr, 8'hA5, 8'h0F, 0, 0, 1'b0);
  endtask

  task automatic test_spurious_done();
    do_op(OpAnd, 8'hF0, 8'h3C, 2, 1, 1'b1);
  endtask

  task automatic test_reset_mid_wait();
    bus.cmd_valid = 1'b1; bus.cmd_op = OpAdd; bus.cmd_a = 8'h21; bus.cmd_b = 8'h43;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.cmd_ready, bus.opcode_valid, bus.opcode, bus.data, bus.rsp_valid,
           bus.rsp_result, bus.rsp_overflow, bus.rsp_timeout} !== 21'h0) begin
        errors++;
        $display("FAIL mid_reset_outputs sample %0d got ready %b valid %b res %h exp 0", i,
                 bus.cmd_ready, bus.rsp_valid, bus.rsp_result);
      end
      if (i < 2) @(negedge clk);
    end
    reset_n = 1'b1;
    bus.done = 1'b1; bus.result = 8'($urandom); bus.overflow = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_overflow, bus.rsp_result}
          !== {3'b100, 8'h00}) begin
        errors++;
        $display("FAIL late_done got ready %b valid %b o%b %h exp 1 0 0 00", bus.cmd_ready,
                 bus.rsp_valid, bus.rsp_overflow, bus.rsp_result);
      end
    end
    bus.done = 1'b0;
  endtask

  task automatic test_timeout();
    // done on the terminal count cycle still gives a normal response
    do_op(OpAdd, 8'h12, 8'h34, 7, 0, 1'b0);
    bus.cmd_valid = 1'b1; bus.cmd_op = OpSub; bus.cmd_a = 8'h55; bus.cmd_b = 8'h11;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
`ifdef ALU_SEQ_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL timeout_early cycle %0d got %b exp 0", i, bus.rsp_valid);
      end
      @(negedge clk);
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_overflow, bus.rsp_result}
        !== {3'b110, 8'h00}) begin
      errors++;
      $display("FAIL timeout_rsp got v%b t%b o%b %h exp v1 t1 o0 00", bus.rsp_valid,
               bus.rsp_timeout, bus.rsp_overflow, bus.rsp_result);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.rsp_timeout, bus.cmd_ready} !== 3'b011) begin
      errors++;
      $display("FAIL timeout_retained got v%b t%b r%b exp v0 t1 r1", bus.rsp_valid,
               bus.rsp_timeout, bus.cmd_ready);
    end
`else
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL no_timeout cycle %0d got %b exp 0", i, bus.rsp_valid);
      end
      @(negedge clk);
    end
    bus.done = 1'b1; bus.result = 8'h44; bus.overflow = 1'b0;
    @(negedge clk);
    bus.done = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_overflow, bus.rsp_result}
        !== {3'b100, 8'h44}) begin
      errors++;
      $display("FAIL late_rsp got v%b t%b o%b %h exp v1 t0 o0 44", bus.rsp_valid,
               bus.rsp_timeout, bus.rsp_overflow, bus.rsp_result);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
`endif
    // a normal response afterwards clears the timeout flag
    do_op(OpOr, 8'h01, 8'h80, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      do_op(2'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 3)), 1'($urandom));
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.done = 1'b0; bus.overflow = 1'b0; bus.result = '0; bus.rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_overflow();
    test_back_to_back();
    test_spurious_done();
    test_reset_mid_wait();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got no finish exp finish before 200000");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand/result width; SHALL match the shared package value.
REQ-002 Parameter TIMEOUT_CYCLES, default 64, the maximum number of WAIT_DONE cycles before abort.
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n, input, 1, asynchronous active-low reset.
REQ-005 Command ports: cmd_valid input 1; cmd_ready output 1; cmd_op input 2 (opcode); cmd_a input DATA_WIDTH; cmd_b input DATA_WIDTH.
REQ-006 ALU-side ports: opcode_valid output 1; opcode output 1 (serial opcode bit); data output DATA_WIDTH; done input 1; overflow input 1; result input DATA_WIDTH.
REQ-007 Response ports: rsp_valid output 1; rsp_ready input 1; rsp_result output DATA_WIDTH; rsp_overflow output 1; rsp_timeout output 1.

Function
REQ-008 States SHALL be IDLE, SEND_A, SEND_B, WAIT_DONE and RESP, and each state SHALL be one-hot-decodable.
REQ-009 cmd_ready SHALL be 1 only in IDLE; a handshake (cmd_valid & cmd_ready) SHALL register cmd_op/cmd_a/cmd_b and move the FSM to SEND_A.
REQ-010 SEND_A (1 cycle): opcode_valid=1, opcode=op[1], data=A; next state is SEND_B.
REQ-011 SEND_B (1 cycle): opcode_valid=1, opcode=op[0], data=B; next state is WAIT_DONE.
REQ-012 Outside SEND_A/SEND_B, opcode_valid, opcode and data SHALL all be 0.
REQ-013 done SHALL be sampled only in WAIT_DONE; a done asserted in IDLE, SEND_A, SEND_B or RESP SHALL be ignored.
REQ-014 done=1 in WAIT_DONE SHALL capture result and overflow into rsp_result/rsp_overflow, clear rsp_timeout, and move the FSM to RESP.
REQ-015 RESP SHALL hold rsp_valid=1 with stable response fields until rsp_ready=1, then return to IDLE.
REQ-016 Best-case latency SHALL be 3 cycles from the command handshake to rsp_valid: 2 send cycles, then done sampled on the first WAIT_DONE cycle.
REQ-017 rsp_valid and cmd_ready SHALL never both be 1 in the same cycle; only one operation SHALL be in flight.
REQ-018 Response fields SHALL keep their last values after the RESP handshake until the next capture.

Reset
REQ-019 On reset_n=0, the FSM SHALL go to IDLE immediately regardless of state.
REQ-020 On reset_n=0, the reset output values SHALL be: cmd_ready=0 while reset_n=0, then 1 from the first post-reset cycle; opcode_valid=0, opcode=0, data=0, rsp_valid=0, rsp_result=0, rsp_overflow=0, rsp_timeout=0.
REQ-021 Reset mid-operation SHALL discard the operation without emitting a response; a late done from the ALU after reset SHALL be ignored per REQ-013.

Configuration
REQ-022 Macro ALU_SEQ_TIMEOUT_EN defined: a counter SHALL run in WAIT_DONE.
  - It SHALL be cleared on WAIT_DONE entry.
  - If TIMEOUT_CYCLES cycles elapse without done, the FSM SHALL enter RESP with rsp_timeout=1, rsp_result=0 and rsp_overflow=0.
  - done arriving on the terminal count cycle SHALL win, giving a normal response.
REQ-023 Macro ALU_SEQ_TIMEOUT_EN undefined: no counter SHALL be built, WAIT_DONE SHALL wait indefinitely, and rsp_timeout SHALL be tied to 0.

Structure
REQ-024 DATA_WIDTH, the 2-bit opcode typedef/constants (ADD=00, SUB=01, AND=10, OR=11) and the FSM state encoding SHALL live in the shared ALU package.
REQ-025 There SHALL be one sub-module, alu_seq_timer, containing the timeout counter; it SHALL be instantiated only under ALU_SEQ_TIMEOUT_EN.
REQ-026 The block SHALL sit directly upstream of simple_alu in the top-level bench, replacing the direct stimulus drive, with the checker still monitoring the ALU-side bus.

Verification
REQ-027 ADD: cmd_op=00, A=0x12, B=0x34 -> opcode_valid high for 2 cycles with opcode 0 then 0 and data 0x12 then 0x34; response rsp_result=0x46, rsp_overflow=0.
REQ-028 Overflow: cmd_op=00, A=0xFF, B=0x01 -> rsp_result=0x00, rsp_overflow=1.
REQ-029 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> response held stable, cmd_ready=0 throughout; then a new command is accepted the cycle after the rsp handshake.
REQ-030 Spurious done: pulse done during SEND_A -> no capture, no state change; the normal response follows the real done.
REQ-031 Reset mid-WAIT_DONE: assert reset_n=0 for 2 cycles -> all outputs at reset values, no rsp_valid, cmd_ready=1 after release.
REQ-032 Timeout: with ALU_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, done held low -> rsp_valid with rsp_timeout=1 after 8 WAIT_DONE cycles; without the macro -> no response.
